// File: rtl/arb_rr_1hot_mux.sv
// Round-robin, burst-locking arbiter in front of a single registered output channel.
// The grant is one-hot; the selected beat is steered by an AND-OR mux and then registered.
module arb_rr_1hot_mux #(
    parameter int unsigned INPUTS = 4,
    parameter int unsigned WIDTH  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [INPUTS-1:0]       i_req_valid,
    input  logic [INPUTS-1:0]       i_req_last,
    input  logic [WIDTH*INPUTS-1:0] i_req_data,
    output logic [INPUTS-1:0]       o_req_ready,
    input  logic [WIDTH-1:0]        i_dflt,
    output logic [INPUTS-1:0]       o_grant,
    output logic                    o_out_valid,
    output logic                    o_out_last,
    output logic [INPUTS-1:0]       o_out_src,
    output logic [WIDTH-1:0]        o_out_data,
    input  logic                    i_out_ready
);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e            r_state, w_state_next;
    logic [INPUTS-1:0] r_ptr, w_ptr_next;
    logic [INPUTS-1:0] r_lock, w_lock_next;
    logic [INPUTS-1:0] w_pick, w_grant;
    logic              w_load_en, w_xfer, w_sel_last;
    logic [WIDTH-1:0]  w_sel_data;
    logic              r_out_valid, r_out_last;
    logic [INPUTS-1:0] r_out_src;
    logic [WIDTH-1:0]  r_data;

    function automatic logic [INPUTS-1:0] rotl1(input logic [INPUTS-1:0] v);
        return {v[INPUTS-2:0], v[INPUTS-1]};
    endfunction

    // First valid requester at or after the pointer, wrapping past INPUTS-1.
    always_comb begin
        w_pick = '0;
        for (int unsigned k = 0; k < INPUTS; k++) begin
            for (int unsigned i = 0; i < INPUTS; i++) begin
                if (r_ptr[i] && (w_pick == '0) && i_req_valid[(i + k) % INPUTS]) begin
                    w_pick[(i + k) % INPUTS] = 1'b1;
                end
            end
        end
    end

    assign w_load_en   = !r_out_valid || i_out_ready;
    assign w_xfer      = (|(w_grant & i_req_valid)) && w_load_en;
    assign w_sel_last  = |(w_grant & i_req_last);
    assign o_req_ready = w_grant & {INPUTS{w_load_en}};
    assign o_grant     = w_grant;

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            w_sel_data = w_sel_data | (i_req_data[WIDTH*i +: WIDTH] & {WIDTH{w_grant[i]}});
        end
        if (w_grant == '0) begin
            w_sel_data = i_dflt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_ptr   <= {{(INPUTS-1){1'b0}}, 1'b1};
            r_lock  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_lock  <= w_lock_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_lock_next  = r_lock;
        unique case (r_state)
            StIdle: begin
                if (w_xfer) begin
                    if (w_sel_last) begin
                        w_ptr_next = rotl1(w_grant);
                    end else begin
                        w_lock_next  = w_grant;
                        w_state_next = StBurst;
                    end
                end
            end
            StBurst: begin
                if (w_xfer && w_sel_last) begin
                    w_ptr_next   = rotl1(r_lock);
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Inside a burst the lock holds the grant even when the locked requester idles.
    always_comb begin
        w_grant = '0;
        unique case (r_state)
            StIdle:  w_grant = w_pick;
            StBurst: w_grant = r_lock;
            default: w_grant = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
            r_data      <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_sel_last;
            r_out_src   <= w_grant;
            r_data      <= w_sel_data;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_last  = r_out_last;
    assign o_out_src   = r_out_src;
    assign o_out_data  = r_out_valid ? r_data : i_dflt;

endmodule
